// File: rtl/fft_out_reader.sv
// fft_out_reader
//   Pulls one transformed frame at a time out of the fft64 frame buffer.
//   It packs the bins into 128-bit words and buffers those words in a small
//   FIFO that feeds a ready/valid writer.
//
//   Optional feature (macro FFT_RD_MAG_EN): each bin is reduced to the
//   unsigned 16-bit value |xr|+|xi|, and eight bins are packed per word.
//   When the macro is undefined, each bin is packed as {re16, im16} and four
//   bins go into each word.
//
// Parameters
//   FRAME_LEN : complex bins per frame (power of two, 8..256)
//   DEPTH     : output FIFO depth in 128-bit words (>= 2)
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-low reset
//   full         in   fft64 holds a complete frame (looked at only in IDLE)
//   valid_o      in   fft64 sample on xr/xi is valid (one cycle after rd_en)
//   xr, xi       in   signed 11-bit real / imaginary parts of the bin
//   rd_en        out  request one bin from fft64
//   writer_data  out  FIFO head word (zero while the FIFO is empty)
//   writer_valid out  FIFO non-empty
//   writer_ready in   downstream accepts the head word
//   frame_done   out  pulse when the last word of a frame is pushed
//   err          out  sticky protocol error
//   state        out  FSM state code (IDLE=0, READ=1, DRAIN=2)
module fft_out_reader #(
  parameter int FRAME_LEN = 64,
  parameter int DEPTH     = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         full,
  input  logic         valid_o,
  input  logic [10:0]  xr,
  input  logic [10:0]  xi,
  output logic         rd_en,
  output logic [127:0] writer_data,
  output logic         writer_valid,
  input  logic         writer_ready,
  output logic         frame_done,
  output logic         err,
  output logic [1:0]   state
);

`ifdef FFT_RD_MAG_EN
  localparam int BPW = 8;
`else
  localparam int BPW = 4;
`endif
  localparam int LW    = 128 / BPW;
  localparam int LANEW = $clog2(BPW);
  localparam int CW    = $clog2(FRAME_LEN + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int OW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     req_cnt_q, req_cnt_d;
  logic              pend_q;
  logic [LANEW-1:0]  lane_q, lane_d;
  logic [127:0]      word_q, word_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              err_q, err_d;
  logic [127:0]      mem_q [DEPTH];

  logic [LW-1:0]     bin_val;
  logic [127:0]      word_fill;
  logic              accept, spurious, push, push_ok, pop, fifo_full;

`ifdef FFT_RD_MAG_EN
  logic [11:0] abs_r, abs_i;
  always_comb begin
    // Negating the 12-bit sign-extended value also covers -1024.
    abs_r   = xr[10] ? (12'd0 - {1'b1, xr}) : {1'b0, xr};
    abs_i   = xi[10] ? (12'd0 - {1'b1, xi}) : {1'b0, xi};
    bin_val = {4'd0, abs_r} + {4'd0, abs_i};
  end
`else
  assign bin_val = {{5{xr[10]}}, xr, {5{xi[10]}}, xi};
`endif

  // A sample counts only if it answers a request made in the previous cycle.
  assign accept   = valid_o & pend_q;
  assign spurious = valid_o & ~pend_q;
  assign push     = accept & (lane_q == LANEW'(BPW - 1));

  // The partial word with the incoming bin merged into its lane. This is
  // the value pushed when the word completes in the same cycle.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    assign word_fill[gi*LW +: LW] = (lane_q == LANEW'(gi)) ? bin_val
                                                          : word_q[gi*LW +: LW];
  end

  assign writer_valid = (occ_q != '0);
  assign writer_data  = writer_valid ? mem_q[rd_ptr_q] : '0;
  assign pop          = writer_valid & writer_ready;
  assign fifo_full    = (occ_q == OW'(DEPTH));
  // A simultaneous pop frees the slot being written, so a push is still legal.
  assign push_ok      = push & (~fifo_full | pop);
  assign err          = err_q;
  assign state        = state_q;

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    lane_d     = lane_q;
    word_d     = word_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    err_d      = err_q | spurious | (push & fifo_full & ~pop);

    case (state_q)
      S_IDLE: begin
        req_cnt_d = '0;
        if (full) state_d = S_READ;
      end
      S_READ: begin
        // One slot is held back for the word that may complete while a
        // request is still in flight.
        if ((occ_q < OW'(DEPTH - 1)) && (req_cnt_q < CW'(FRAME_LEN))) begin
          rd_en     = 1'b1;
          req_cnt_d = req_cnt_q + CW'(1);
          if (req_cnt_q == CW'(FRAME_LEN - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The only sample arriving here is the frame's last bin, so any
        // push in DRAIN is the final word.
        if (push) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      lane_d = lane_q + LANEW'(1);
      word_d = push ? '0 : word_fill;
    end

    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      req_cnt_q <= '0;
      pend_q    <= 1'b0;
      lane_q    <= '0;
      word_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      pend_q    <= rd_en;
      lane_q    <= lane_d;
      word_q    <= word_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= word_fill;
  end

endmodule

// File: doc/fft_out_reader.md
FFT_OUT_READER -- requirements
Module: fft_out_reader

Interface
REQ-001 Parameter FRAME_LEN, default 64: complex bins per frame; power of two, 8..256.
REQ-002 Parameter DEPTH, default 4: output word-FIFO depth in 128-bit words, at least 2.
REQ-003 CLK  input  1  single clock; all logic on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-low.
REQ-005 full  input  1  the fft64 frame buffer holds a complete transformed frame.
REQ-006 valid_o  input  1  the fft64 output sample on xr/xi is valid this cycle.
REQ-007 xr  input  11  signed real part of the output bin.
REQ-008 xi  input  11  signed imaginary part of the output bin.
REQ-009 rd_en  output  1  pull request to fft64: one bin per asserted cycle.
REQ-010 writer_data  output  128  packed output word.
REQ-011 writer_valid  output  1  writer_data is valid.
REQ-012 writer_ready  input  1  the downstream writer accepts the word.
REQ-013 frame_done  output  1  one-cycle pulse when the last word of a frame enters the FIFO.
REQ-014 err  output  1  sticky protocol-error flag.
REQ-015 state  output  2  current FSM state code.

Function
REQ-016 The fft64 contract: rd_en high in cycle t yields valid_o with data in cycle t+1; the block relies on exactly this.
REQ-017 The FSM has three states: IDLE=0, READ=1, DRAIN=2.
REQ-018 IDLE goes to READ on the first cycle with full=1; rd_en=0 in IDLE.
REQ-019 In READ, rd_en=1 when FIFO occupancy < DEPTH-1 and the request count < FRAME_LEN; otherwise rd_en=0.
REQ-020 The request counter increments on each rd_en cycle; when it reaches FRAME_LEN the FSM goes to DRAIN.
REQ-021 DRAIN returns to IDLE on the cycle after the final packed word is pushed; frame_done pulses on that push cycle.
REQ-022 Each sample with valid_o=1 is sign-extended to 16 bits per component and placed as {re16, im16}, 32 bits per bin.
REQ-023 Four bins fill one word, bin k of the word at bits [32k+31:32k], so the first bin occupies the LSBs; FRAME_LEN/4 words make a frame.
REQ-024 A completed word is pushed into the FIFO in the same cycle its 4th bin arrives.
REQ-025 The FIFO head is presented on writer_data with writer_valid=1 whenever the FIFO is non-empty.
REQ-026 A word is popped on writer_valid & writer_ready.
REQ-027 A push and a pop in the same cycle leave occupancy unchanged; this is legal when the FIFO is full.
REQ-028 writer_data must not change while writer_valid=1 and writer_ready=0.
REQ-029 The FIFO pointers wrap modulo DEPTH; overflow is impossible by REQ-019, and a push while full sets err and drops the word.
REQ-030 valid_o=1 with no request outstanding from the previous cycle sets err and the sample is ignored.
REQ-031 err stays set until reset.
REQ-032 full is sampled only in IDLE; its value in READ and DRAIN is ignored.

Reset
REQ-033 While RST=0 the block is asynchronously forced to: state=IDLE, counters=0, partial word cleared, FIFO empty.
REQ-034 While RST=0 the outputs are: rd_en=0, writer_valid=0, writer_data=0, frame_done=0, err=0.
REQ-035 Reset asserted mid-frame discards all partial and buffered data; no word is emitted after release until a new full.
REQ-036 The first request after release can occur no earlier than the second rising edge after RST rises.

Configuration
REQ-037 With macro FFT_RD_MAG_EN defined, each bin is reduced to the unsigned 16-bit value |xr|+|xi|.
REQ-038 With FFT_RD_MAG_EN defined, eight bins form one word (bin k at bits [16k+15:16k]) and a frame is FRAME_LEN/8 words; all handshakes are unchanged.
REQ-039 Without FFT_RD_MAG_EN, complex packing per REQ-022 and REQ-023 applies.

Verification
REQ-040 Impulse frame: bin0=(256,0), other bins 0, writer_ready=1 -> 16 words; word0 = 0x...0000_0000_0100_0000, words 1..15 = 0; one frame_done pulse; err=0.
REQ-041 Sign extension: bin (-1,-1024) -> its lane reads 0xFFFF_FC00; with FFT_RD_MAG_EN the lane reads 0x0401.
REQ-042 Backpressure: hold writer_ready=0 -> rd_en deasserts after DEPTH-1 words are buffered; releasing it gives all 16 words in order with no loss or duplication.
REQ-043 Protocol error: inject valid_o=1 with no prior rd_en -> err=1 the next cycle, stays 1, and the output data is unaffected.
REQ-044 Reset mid-frame: pull RST low after 20 bins -> outputs at reset values immediately; a new frame after release gives exactly 16 clean words.
REQ-045 Back-to-back frames: full held high -> the second frame starts in the cycle after frame_done and no bin gaps appear beyond FIFO stalls.
